// File: rtl/alu_rs_bank.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs_bank
// Purpose  : Bank of ALU reservation stations sitting behind issue_logic.
//            Captures issued operands/tags, snoops the CDB to resolve pending
//            operands, dispatches ready entries oldest-first to one ALU over a
//            valid/ready handshake, and frees each entry when its own tag is
//            broadcast on the CDB.
// Ports    : clk_i, reset_ni      - clock (rising edge), async active-low reset
//            cdb_i               - CDB {tag, val}; tag == NO_VAL means idle
//            write_en_i          - one-hot entry write strobe from issue_logic
//            value1_i/value2_i   - operand values
//            tag1_i/tag2_i       - operand producer tags (NO_VAL = value valid)
//            alu_op_i/shift_op_i - operation to capture
//            busy_o              - per-entry occupied flag back to issue_logic
//            alu_valid_o/alu_ready_i - dispatch handshake
//            alu_a_o/alu_b_o/alu_op_o/alu_shift_op_o/alu_tag_o - dispatch payload
// Revision : 1.0 - initial release
// ============================================================================
module alu_rs_bank #(
  parameter int               NUM_ENTRIES = 3,
  parameter int               TAG_W       = 4,
  parameter int               OP_W        = 4,
  parameter int               SHIFT_W     = 2,
  parameter logic [TAG_W-1:0] NO_VAL      = '0,
  parameter logic [TAG_W-1:0] BASE_TAG    = {{(TAG_W-1){1'b0}}, 1'b1}
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [TAG_W+31:0]      cdb_i,
  input  logic [NUM_ENTRIES-1:0] write_en_i,
  input  logic [31:0]            value1_i,
  input  logic [31:0]            value2_i,
  input  logic [TAG_W-1:0]       tag1_i,
  input  logic [TAG_W-1:0]       tag2_i,
  input  logic [OP_W-1:0]        alu_op_i,
  input  logic [SHIFT_W-1:0]     shift_op_i,
  output logic [NUM_ENTRIES-1:0] busy_o,
  output logic                   alu_valid_o,
  input  logic                   alu_ready_i,
  output logic [31:0]            alu_a_o,
  output logic [31:0]            alu_b_o,
  output logic [OP_W-1:0]        alu_op_o,
  output logic [SHIFT_W-1:0]     alu_shift_op_o,
  output logic [TAG_W-1:0]       alu_tag_o
);

  localparam int               AGE_W   = $clog2(NUM_ENTRIES) + 1;
  localparam int               IDX_W   = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {
    S_FREE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2,
    S_EXEC  = 2'd3
  } rs_state_e;

  // Per-entry storage
  rs_state_e          state_q [NUM_ENTRIES];
  logic [31:0]        val1_q  [NUM_ENTRIES];
  logic [31:0]        val2_q  [NUM_ENTRIES];
  logic [TAG_W-1:0]   tag1_q  [NUM_ENTRIES];
  logic [TAG_W-1:0]   tag2_q  [NUM_ENTRIES];
  logic [OP_W-1:0]    op_q    [NUM_ENTRIES];
  logic [SHIFT_W-1:0] sop_q   [NUM_ENTRIES];
  logic [AGE_W-1:0]   age_q   [NUM_ENTRIES];

  // Dispatch register
  logic               disp_valid_q;
  logic [31:0]        disp_a_q;
  logic [31:0]        disp_b_q;
  logic [OP_W-1:0]    disp_op_q;
  logic [SHIFT_W-1:0] disp_sop_q;
  logic [TAG_W-1:0]   disp_tag_q;

  // CDB decode
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_val;
  logic             cdb_live;
  assign cdb_tag  = cdb_i[TAG_W+31:32];
  assign cdb_val  = cdb_i[31:0];
  assign cdb_live = (cdb_tag != NO_VAL);

  // Write capture with same-cycle CDB bypass: a producer broadcasting on the
  // very edge we capture would otherwise be missed forever.
  logic             byp1, byp2;
  logic [31:0]      cap_val1, cap_val2;
  logic [TAG_W-1:0] cap_tag1, cap_tag2;
  assign byp1     = cdb_live && (tag1_i == cdb_tag);
  assign byp2     = cdb_live && (tag2_i == cdb_tag);
  assign cap_val1 = byp1 ? cdb_val : value1_i;
  assign cap_val2 = byp2 ? cdb_val : value2_i;
  assign cap_tag1 = byp1 ? NO_VAL : tag1_i;
  assign cap_tag2 = byp2 ? NO_VAL : tag2_i;

  logic [TAG_W-1:0]       own_tag [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] occupied, wr_fire, res1, res2, pend1_d, pend2_d, free_hit, sel_oh;
  logic                   any_write;

  logic             any_ready;
  logic [IDX_W-1:0] sel_idx;
  logic [AGE_W-1:0] sel_age;
  logic             disp_fire;

  genvar gk;
  generate
    for (gk = 0; gk < NUM_ENTRIES; gk++) begin : g_entry
      assign own_tag[gk]  = BASE_TAG + TAG_W'(gk);
      assign occupied[gk] = (state_q[gk] != S_FREE);
      assign wr_fire[gk]  = write_en_i[gk] && (state_q[gk] == S_FREE);
      // Snoop hits; cdb_live guarantees the stored tag is not NO_VAL
      assign res1[gk]     = cdb_live && (tag1_q[gk] == cdb_tag);
      assign res2[gk]     = cdb_live && (tag2_q[gk] == cdb_tag);
      assign pend1_d[gk]  = (tag1_q[gk] != NO_VAL) && !res1[gk];
      assign pend2_d[gk]  = (tag2_q[gk] != NO_VAL) && !res2[gk];
      assign free_hit[gk] = cdb_live && (cdb_tag == own_tag[gk]);
      assign sel_oh[gk]   = disp_fire && (sel_idx == IDX_W'(gk));
    end
  endgenerate

  assign any_write = |wr_fire;
  assign busy_o    = occupied;

  // Oldest READY entry wins; ages of occupied entries are always distinct.
  always_comb begin
    any_ready = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (state_q[k] == S_READY && (!any_ready || age_q[k] > sel_age)) begin
        any_ready = 1'b1;
        sel_idx   = IDX_W'(k);
        sel_age   = age_q[k];
      end
    end
  end

  assign disp_fire = any_ready && (!disp_valid_q || alu_ready_i);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        state_q[k] <= S_FREE;
        val1_q[k]  <= '0;
        val2_q[k]  <= '0;
        tag1_q[k]  <= NO_VAL;
        tag2_q[k]  <= NO_VAL;
        op_q[k]    <= '0;
        sop_q[k]   <= '0;
        age_q[k]   <= '0;
      end
      disp_valid_q <= 1'b0;
      disp_a_q     <= '0;
      disp_b_q     <= '0;
      disp_op_q    <= '0;
      disp_sop_q   <= '0;
      disp_tag_q   <= NO_VAL;
    end else begin
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        if (any_write && occupied[k] && age_q[k] != AGE_MAX)
          age_q[k] <= age_q[k] + 1'b1;

        unique case (state_q[k])
          S_FREE: begin
            if (wr_fire[k]) begin
              val1_q[k]  <= cap_val1;
              val2_q[k]  <= cap_val2;
              tag1_q[k]  <= cap_tag1;
              tag2_q[k]  <= cap_tag2;
              op_q[k]    <= alu_op_i;
              sop_q[k]   <= shift_op_i;
              age_q[k]   <= '0;
              state_q[k] <= (cap_tag1 == NO_VAL && cap_tag2 == NO_VAL) ? S_READY : S_WAIT;
            end
          end
          S_WAIT: begin
            if (res1[k]) begin
              val1_q[k] <= cdb_val;
              tag1_q[k] <= NO_VAL;
            end
            if (res2[k]) begin
              val2_q[k] <= cdb_val;
              tag2_q[k] <= NO_VAL;
            end
            if (!pend1_d[k] && !pend2_d[k])
              state_q[k] <= S_READY;
          end
          S_READY: begin
            if (sel_oh[k])
              state_q[k] <= S_EXEC;
          end
          S_EXEC: begin
            if (free_hit[k])
              state_q[k] <= S_FREE;
          end
          default: state_q[k] <= S_FREE;
        endcase
      end

      if (disp_fire) begin
        disp_valid_q <= 1'b1;
        disp_a_q     <= val1_q[sel_idx];
        disp_b_q     <= val2_q[sel_idx];
        disp_op_q    <= op_q[sel_idx];
        disp_sop_q   <= sop_q[sel_idx];
        disp_tag_q   <= own_tag[sel_idx];
      end else if (alu_ready_i) begin
        disp_valid_q <= 1'b0;
      end
    end
  end

  assign alu_valid_o    = disp_valid_q;
  assign alu_a_o        = disp_a_q;
  assign alu_b_o        = disp_b_q;
  assign alu_op_o       = disp_op_q;
  assign alu_shift_op_o = disp_sop_q;
  assign alu_tag_o      = disp_tag_q;

  // issue_logic must never write an occupied entry or strobe two entries
  a_write_onehot: assert property (@(posedge clk_i) disable iff (!reset_ni)
                                   $onehot0(write_en_i));
  a_write_free:   assert property (@(posedge clk_i) disable iff (!reset_ni)
                                   (write_en_i & occupied) == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_rs_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rs_bank
// Purpose  : Directed self-checking bench for alu_rs_bank (3 entries,
//            4-bit tags, NO_VAL=0, ALU_1..ALU_3 = 1..3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rs_bank;

  localparam logic [3:0] NOV    = 4'd0;
  localparam logic [3:0] ALU_1  = 4'd1;
  localparam logic [3:0] ALU_2  = 4'd2;
  localparam logic [3:0] ALU_3  = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [35:0] cdb;
  logic [2:0]  write_en;
  logic [31:0] value1, value2;
  logic [3:0]  tag1, tag2;
  logic [3:0]  alu_op;
  logic [1:0]  shift_op;
  logic [2:0]  busy;
  logic        alu_valid;
  logic        alu_ready;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op_out;
  logic [1:0]  alu_shift_out;
  logic [3:0]  alu_tag;

  int vectors     = 0;
  int miscompares = 0;

  alu_rs_bank dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .cdb_i          (cdb),
    .write_en_i     (write_en),
    .value1_i       (value1),
    .value2_i       (value2),
    .tag1_i         (tag1),
    .tag2_i         (tag2),
    .alu_op_i       (alu_op),
    .shift_op_i     (shift_op),
    .busy_o         (busy),
    .alu_valid_o    (alu_valid),
    .alu_ready_i    (alu_ready),
    .alu_a_o        (alu_a),
    .alu_b_o        (alu_b),
    .alu_op_o       (alu_op_out),
    .alu_shift_op_o (alu_shift_out),
    .alu_tag_o      (alu_tag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_en = 3'b000;
    cdb      = '0;
    tag1     = NOV;
    tag2     = NOV;
  endtask

  task automatic wr(input logic [2:0] en, input logic [31:0] v1, input logic [3:0] t1,
                    input logic [31:0] v2, input logic [3:0] t2,
                    input logic [3:0] op, input logic [1:0] sh);
    write_en = en;
    value1   = v1;
    tag1     = t1;
    value2   = v2;
    tag2     = t2;
    alu_op   = op;
    shift_op = sh;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    alu_ready = 1'b1;
    value1 = '0; value2 = '0; alu_op = '0; shift_op = '0;
    idle();
    #2;
    vectors++; if (busy !== 3'b000) begin $display("FAIL reset_busy got=%b exp=000", busy); miscompares++; end
    vectors++; if (alu_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", alu_valid); miscompares++; end
    vectors++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin $display("FAIL reset_ab got=%h/%h exp=0/0", alu_a, alu_b); miscompares++; end
    vectors++; if (alu_tag !== NOV) begin $display("FAIL reset_tag got=%0d exp=%0d", alu_tag, NOV); miscompares++; end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    alu_ready = 1'b1;
    wr(3'b001, 32'd7, NOV, 32'd5, NOV, OP_ADD, 2'd0);
    tick(); idle();
    vectors++; if (busy !== 3'b001) begin $display("FAIL basic_busy got=%b exp=001", busy); miscompares++; end
    vectors++; if (alu_valid !== 1'b0) begin $display("FAIL basic_early_valid got=%b exp=0", alu_valid); miscompares++; end
    tick();
    vectors++;
    if ({alu_valid, alu_a, alu_b, alu_tag, alu_op_out} !== {1'b1, 32'd7, 32'd5, ALU_1, OP_ADD}) begin
      $display("FAIL basic_dispatch got=v%b a=%0d b=%0d t=%0d op=%0d exp=v1 a=7 b=5 t=1 op=1",
               alu_valid, alu_a, alu_b, alu_tag, alu_op_out);
      miscompares++;
    end
    cdb = {ALU_1, 32'd12};
    tick(); idle();
    vectors++; if (busy !== 3'b000) begin $display("FAIL basic_free got=%b exp=000", busy); miscompares++; end
    vectors++; if (alu_valid !== 1'b0) begin $display("FAIL basic_drop got=%b exp=0", alu_valid); miscompares++; end
  endtask

  task automatic test_wait_resolve();
    alu_ready = 1'b1;
    wr(3'b100, 32'hDEAD_BEEF, ALU_1, 32'd3, NOV, OP_SUB, 2'd0);
    tick(); idle();
    vectors++; if (busy !== 3'b100) begin $display("FAIL wait_busy got=%b exp=100", busy); miscompares++; end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (alu_valid !== 1'b0) begin $display("FAIL wait_hold%0d got=%b exp=0", i, alu_valid); miscompares++; end
    end
    cdb = {ALU_1, 32'hFFFF_FFFB};
    tick(); idle();
    vectors++; if (alu_valid !== 1'b0) begin $display("FAIL wait_resolve_edge got=%b exp=0", alu_valid); miscompares++; end
    tick();
    vectors++;
    if ({alu_valid, alu_a, alu_b, alu_tag} !== {1'b1, 32'hFFFF_FFFB, 32'd3, ALU_3}) begin
      $display("FAIL wait_dispatch got=v%b a=%h b=%h t=%0d exp=v1 a=fffffffb b=3 t=3",
               alu_valid, alu_a, alu_b, alu_tag);
      miscompares++;
    end
    cdb = {ALU_3, 32'd0};
    tick(); idle();
    vectors++; if (busy !== 3'b000) begin $display("FAIL wait_free got=%b exp=000", busy); miscompares++; end
  endtask

  task automatic test_bypass();
    alu_ready = 1'b1;
    wr(3'b010, 32'd4, NOV, 32'd100, ALU_3, OP_ADD, 2'd0);
    cdb = {ALU_3, 32'd9};
    tick(); idle();
    vectors++; if (busy !== 3'b010 || alu_valid !== 1'b0) begin $display("FAIL bypass_capture got=busy%b v%b exp=busy010 v0", busy, alu_valid); miscompares++; end
    tick();
    vectors++;
    if ({alu_valid, alu_a, alu_b, alu_tag} !== {1'b1, 32'd4, 32'd9, ALU_2}) begin
      $display("FAIL bypass_dispatch got=v%b a=%0d b=%0d t=%0d exp=v1 a=4 b=9 t=2",
               alu_valid, alu_a, alu_b, alu_tag);
      miscompares++;
    end
    cdb = {ALU_2, 32'd13};
    tick(); idle();
    vectors++; if (busy !== 3'b000) begin $display("FAIL bypass_free got=%b exp=000", busy); miscompares++; end
  endtask

  task automatic test_oldest_first();
    alu_ready = 1'b0;
    wr(3'b100, 32'd30, NOV, 32'd31, NOV, OP_AND, 2'd0); tick();
    wr(3'b001, 32'd10, NOV, 32'd11, NOV, OP_AND, 2'd0); tick();
    wr(3'b010, 32'd20, NOV, 32'd21, NOV, OP_AND, 2'd0); tick();
    idle();
    vectors++; if (busy !== 3'b111) begin $display("FAIL order_busy got=%b exp=111", busy); miscompares++; end
    vectors++; if ({alu_valid, alu_tag, alu_a} !== {1'b1, ALU_3, 32'd30}) begin $display("FAIL order_first got=v%b t=%0d a=%0d exp=v1 t=3 a=30", alu_valid, alu_tag, alu_a); miscompares++; end
    alu_ready = 1'b1;
    tick();
    vectors++; if ({alu_valid, alu_tag, alu_a} !== {1'b1, ALU_1, 32'd10}) begin $display("FAIL order_second got=v%b t=%0d a=%0d exp=v1 t=1 a=10", alu_valid, alu_tag, alu_a); miscompares++; end
    tick();
    vectors++; if ({alu_valid, alu_tag, alu_a} !== {1'b1, ALU_2, 32'd20}) begin $display("FAIL order_third got=v%b t=%0d a=%0d exp=v1 t=2 a=20", alu_valid, alu_tag, alu_a); miscompares++; end
    tick();
    vectors++; if (alu_valid !== 1'b0) begin $display("FAIL order_drain got=%b exp=0", alu_valid); miscompares++; end
    cdb = {ALU_3, 32'd0}; tick();
    cdb = {ALU_1, 32'd0}; tick();
    cdb = {ALU_2, 32'd0}; tick();
    idle();
    vectors++; if (busy !== 3'b000) begin $display("FAIL order_free got=%b exp=000", busy); miscompares++; end
  endtask

  task automatic test_backpressure();
    alu_ready = 1'b0;
    wr(3'b001, 32'h1111_1111, NOV, 32'h2222_2222, NOV, OP_OR, 2'd1); tick();
    wr(3'b010, 32'h3333_3333, NOV, 32'h4444_4444, NOV, OP_SUB, 2'd2); tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      cdb = {4'(5 + i), 32'(i * 7)};
      tick();
      vectors++;
      if ({alu_valid, alu_a, alu_b, alu_tag, alu_op_out, alu_shift_out} !==
          {1'b1, 32'h1111_1111, 32'h2222_2222, ALU_1, OP_OR, 2'd1}) begin
        $display("FAIL stall%0d got=v%b a=%h b=%h t=%0d op=%0d sh=%0d exp=v1 a=11111111 b=22222222 t=1 op=4 sh=1",
                 i, alu_valid, alu_a, alu_b, alu_tag, alu_op_out, alu_shift_out);
        miscompares++;
      end
    end
    cdb = '0;
    alu_ready = 1'b1;
    tick();
    vectors++;
    if ({alu_valid, alu_a, alu_b, alu_tag, alu_op_out, alu_shift_out} !==
        {1'b1, 32'h3333_3333, 32'h4444_4444, ALU_2, OP_SUB, 2'd2}) begin
      $display("FAIL stall_release got=v%b a=%h b=%h t=%0d op=%0d sh=%0d exp=v1 a=33333333 b=44444444 t=2 op=2 sh=2",
               alu_valid, alu_a, alu_b, alu_tag, alu_op_out, alu_shift_out);
      miscompares++;
    end
    tick();
    vectors++; if (alu_valid !== 1'b0) begin $display("FAIL stall_drain got=%b exp=0", alu_valid); miscompares++; end
    cdb = {ALU_1, 32'd0}; tick();
    cdb = {ALU_2, 32'd0}; tick();
    idle();
    vectors++; if (busy !== 3'b000) begin $display("FAIL stall_free got=%b exp=000", busy); miscompares++; end
  endtask

  task automatic test_async_reset();
    alu_ready = 1'b0;
    wr(3'b100, 32'd1, NOV, 32'd2, NOV, OP_ADD, 2'd0); tick();
    wr(3'b001, 32'd0, 4'd6, 32'd8, NOV, OP_ADD, 2'd0); tick();
    wr(3'b010, 32'd9, NOV, 32'd0, 4'd7, OP_ADD, 2'd0); tick();
    idle();
    vectors++; if ({busy, alu_valid, alu_tag} !== {3'b111, 1'b1, ALU_3}) begin $display("FAIL arst_setup got=busy%b v%b t=%0d exp=busy111 v1 t=3", busy, alu_valid, alu_tag); miscompares++; end
    #3;
    reset_n = 1'b0;
    #1;
    vectors++; if (busy !== 3'b000) begin $display("FAIL arst_busy got=%b exp=000", busy); miscompares++; end
    vectors++; if ({alu_valid, alu_tag, alu_a} !== {1'b0, NOV, 32'd0}) begin $display("FAIL arst_disp got=v%b t=%0d a=%0d exp=v0 t=0 a=0", alu_valid, alu_tag, alu_a); miscompares++; end
    #2;
    reset_n = 1'b1;
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_resolve();
    test_bypass();
    test_oldest_first();
    test_backpressure();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_rs_bank.md
Name: alu_rs_bank

Overview:
- Bank of ALU reservation stations directly downstream of issue_logic.
- Captures the operands, tags and op issued by issue_logic into the entry selected by the one-hot rs_write_en slice.
- Snoops the CDB to resolve pending operands and dispatches ready entries oldest-first to a single ALU through a valid/ready handshake.
- Drives the busy bus back to issue_logic and frees each entry when its own tag is broadcast on the CDB.

Parameters:
- NUM_ENTRIES, 3, number of ALU stations in the bank.
- BASE_TAG, ALU_1, rs_tag_t of entry 0. Entry k owns tag BASE_TAG+k.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- cdb_i  in  cdb_t  common data bus {tag, val}. tag==NO_VAL means idle.
- write_en_i  in  NUM_ENTRIES  one-hot entry write strobe (slice of rs_write_en_o).
- value1_i, value2_i  in  word32_t  operand values from issue_logic.
- tag1_i, tag2_i  in  rs_tag_t  producer tags. NO_VAL means the value is valid.
- alu_op_i  in  alu_op_t  ALU operation.
- shift_op_i  in  shift_op_t  shift operation.
- busy_o  out  NUM_ENTRIES  entry occupied (FREE=0), feeds the issue busy_bus_i.
- alu_valid_o  out  1  dispatch payload valid.
- alu_ready_i  in  1  ALU accepts the payload this cycle.
- alu_a_o, alu_b_o  out  word32_t  dispatched operands.
- alu_op_o  out  alu_op_t  dispatched op.
- alu_shift_op_o  out  shift_op_t  dispatched shift op.
- alu_tag_o  out  rs_tag_t  tag of the dispatched entry; the ALU broadcasts its result with this tag.

Behaviour:
- Reset (async, reset_ni=0): all entries FREE, both operand tags NO_VAL, ages 0.
  - busy_o=0, alu_valid_o=0, alu_a_o/alu_b_o=0, alu_tag_o=NO_VAL.
  - Takes effect immediately mid-operation; in-flight dispatch is dropped.
- Per-entry FSM: FREE -> WAIT (write with a pending tag) or READY (write with both tags NO_VAL). WAIT -> READY when the last pending tag resolves. READY -> EXEC when dispatched. EXEC -> FREE on the edge where cdb_i.tag == own tag.
- Write (edge where write_en_i[k]=1 and entry k FREE):
  - Capture the value/tag pair for each operand, plus both ops; age cleared to 0.
  - Same-cycle bypass: if tagN_i != NO_VAL and tagN_i == cdb_i.tag, capture cdb_i.val and store tag NO_VAL.
- Write to a non-FREE entry is ignored; simulation assertion fires.
- More than one write_en_i bit set is illegal; assertion fires.
- Snoop: every edge, each WAIT operand whose tag == cdb_i.tag (cdb_i.tag != NO_VAL) loads cdb_i.val and its tag becomes NO_VAL. Both operands may resolve on the same edge.
- Age: on every write, every other occupied entry saturating-increments its age (width clog2(NUM_ENTRIES)+1).
- Select: among READY entries, highest age wins; ties impossible by construction.
- Dispatch register:
  - Loads the selected entry on an edge when (!alu_valid_o || alu_ready_i) and a READY entry exists. That entry moves to EXEC.
  - If no READY entry exists and alu_ready_i=1, alu_valid_o drops to 0.
  - While alu_valid_o=1 and alu_ready_i=0, all outputs hold stable.
- Latency: write with ready operands at edge E0 -> alu_valid_o=1 after E1. Back-to-back dispatch at one per cycle when alu_ready_i stays high.
- busy_o[k] = (state != FREE), registered. It rises the edge after the write and falls the edge after the CDB broadcast of tag BASE_TAG+k. The entry can be rewritten on the following edge.
- Simultaneous CDB free of entry k and write_en_i[k] on the same edge: write ignored (entry not yet FREE), assertion fires. issue_logic never does this because busy_o is still 1.

Test Plan:
- Reset then write entry 0: tags NO_VAL, value1=7, value2=5, op ADD, alu_ready_i=1 -> busy_o=001; alu_valid_o=1 two edges after write with a=7, b=5, tag=ALU_1. CDB {ALU_1, 12} -> busy_o=000 next edge.
- Write entry 2 with tag1=ALU_1, value2=3. Hold 4 cycles -> alu_valid_o stays 0. CDB {ALU_1, -5} -> dispatch a=-5, b=3, tag=ALU_3.
- Bypass: write entry 1 with tag2=ALU_3 while cdb_i={ALU_3, 9} on the same edge -> stored operand 9, dispatched next edge.
- Oldest-first: write entries 2, 0, 1 on consecutive edges with alu_ready_i=0, all operands ready, then raise alu_ready_i -> dispatch order ALU_3, ALU_1, ALU_2, one per cycle.
- Backpressure: alu_valid_o=1 with alu_ready_i=0 for 5 cycles while cdb_i toggles unrelated tags -> all ALU outputs stable; release -> next entry follows the edge after acceptance.
- Assert reset_ni=0 mid-cycle with two entries in WAIT and dispatch valid -> busy_o=0 and alu_valid_o=0 immediately, without waiting for a clock edge. After release, a new write behaves as in the first scenario.
